// File: rtl/arb_burst_rom_pkg.sv
// Shared types and constant helpers for the arbitrated burst-read ROM.
package arb_burst_rom_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Channel-id width; a single requester still gets a 1-bit id field.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/arb_burst_rom_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, with wrap.
module arb_burst_rom_rr_arbiter
  import arb_burst_rom_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   idx,
  output logic              any
);

  logic [CH_W-1:0] cand;
  logic            hit;

  // Scan from the pointer upward; the first hit wins and masks the rest.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    hit   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand        = CH_W'((int'(ptr) + i) % NUM_CH);
      hit         = req[cand] && !any;
      grant[cand] = grant[cand] | hit;
      idx         = hit ? cand : idx;
      any         = any | hit;
    end
  end

endmodule

// File: rtl/arb_burst_rom.sv
// Shared ROM serving round-robin arbitrated burst reads; beats leave on one
// response bus tagged with channel, last and out-of-range error.
module arb_burst_rom
  import arb_burst_rom_pkg::*;
#(
  parameter int    DATA_WIDTH    = 32,
  parameter int    ADDRESS_WIDTH = 12,
  parameter int    DEPTH         = 250,
  parameter int    NUM_CH        = 2,
  parameter int    LEN_WIDTH     = 8,
  parameter int    OUT_REG       = 0,
  parameter string MEMFILE       = ""
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_CH-1:0]               req_valid,
  output logic [NUM_CH-1:0]               req_ready,
  input  logic [NUM_CH*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_CH*LEN_WIDTH-1:0]     req_len,
  output logic                            rsp_valid,
  output logic [ch_width(NUM_CH)-1:0]     rsp_ch,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            rsp_last,
  output logic                            rsp_err,
  output logic                            busy
);

  localparam int CH_W  = ch_width(NUM_CH);
  localparam int IDX_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                   state_r, state_nxt;
  logic [CH_W-1:0]          rr_ptr_r, ch_r, gnt_idx;
  logic [NUM_CH-1:0]        gnt;
  logic                     gnt_any, handshake, addr_oob, tail_valid;
  logic [ADDRESS_WIDTH-1:0] cur_addr_r, next_addr;
  logic [LEN_WIDTH-1:0]     remaining_r;

  logic                     iss_valid_r, iss_last_r, iss_err_r;
  logic [ADDRESS_WIDTH-1:0] iss_addr_r;
  logic [CH_W-1:0]          iss_ch_r;
  logic [IDX_W-1:0]         rd_idx;

  logic                     rd_valid_r, rd_last_r, rd_err_r;
  logic [CH_W-1:0]          rd_ch_r;
  logic [DATA_WIDTH-1:0]    rd_data_r;

  arb_burst_rom_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // Last valid word wraps to 0; out-of-range addresses run on to the natural wrap.
  assign next_addr = (cur_addr_r == ADDRESS_WIDTH'(DEPTH - 1)) ? '0 : cur_addr_r + 1'b1;
  assign addr_oob  = 32'(cur_addr_r) >= 32'(DEPTH);
  assign rd_idx    = iss_err_r ? '0 : iss_addr_r[IDX_W-1:0];

  // Next-state and request-accept decode.
  always_comb begin
    state_nxt = state_r;
    req_ready = '0;
    handshake = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (gnt_any && reset_n) begin
          req_ready = gnt;
          handshake = 1'b1;
          state_nxt = ST_BURST;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (remaining_r == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_BURST;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Burst bookkeeping: state, round-robin pointer, address and beat counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      ch_r        <= '0;
      cur_addr_r  <= '0;
      remaining_r <= '0;
    end else begin
      state_r <= state_nxt;
      if (handshake) begin
        cur_addr_r  <= req_addr[int'(gnt_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        remaining_r <= req_len[int'(gnt_idx)*LEN_WIDTH +: LEN_WIDTH];
        ch_r        <= gnt_idx;
        rr_ptr_r    <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
      end else if (state_r == ST_BURST) begin
        cur_addr_r  <= next_addr;
        remaining_r <= remaining_r - 1'b1;
      end
    end
  end

  // Issue stage: one tagged read per BURST cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iss_valid_r <= 1'b0;
      iss_addr_r  <= '0;
      iss_ch_r    <= '0;
      iss_last_r  <= 1'b0;
      iss_err_r   <= 1'b0;
    end else begin
      iss_valid_r <= (state_r == ST_BURST);
      if (state_r == ST_BURST) begin
        iss_addr_r <= cur_addr_r;
        iss_ch_r   <= ch_r;
        iss_last_r <= (remaining_r == '0);
        iss_err_r  <= addr_oob;
      end
    end
  end

  // Array read register; payload holds while no beat is flowing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
      rd_ch_r    <= '0;
      rd_last_r  <= 1'b0;
      rd_err_r   <= 1'b0;
    end else begin
      rd_valid_r <= iss_valid_r;
      if (iss_valid_r) begin
        rd_data_r <= iss_err_r ? '0 : mem[rd_idx];
        rd_ch_r   <= iss_ch_r;
        rd_last_r <= iss_last_r;
        rd_err_r  <= iss_err_r;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  out_valid_r, out_last_r, out_err_r;
      logic [CH_W-1:0]       out_ch_r;
      logic [DATA_WIDTH-1:0] out_data_r;

      // Optional retiming stage in front of the response bus.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          out_valid_r <= 1'b0;
          out_data_r  <= '0;
          out_ch_r    <= '0;
          out_last_r  <= 1'b0;
          out_err_r   <= 1'b0;
        end else begin
          out_valid_r <= rd_valid_r;
          if (rd_valid_r) begin
            out_data_r <= rd_data_r;
            out_ch_r   <= rd_ch_r;
            out_last_r <= rd_last_r;
            out_err_r  <= rd_err_r;
          end
        end
      end

      assign tail_valid = rd_valid_r;
      assign rsp_valid  = out_valid_r;
      assign rsp_data   = out_data_r;
      assign rsp_ch     = out_ch_r;
      assign rsp_last   = out_last_r;
      assign rsp_err    = out_err_r;
    end else begin : g_no_out_reg
      assign tail_valid = 1'b0;
      assign rsp_valid  = rd_valid_r;
      assign rsp_data   = rd_data_r;
      assign rsp_ch     = rd_ch_r;
      assign rsp_last   = rd_last_r;
      assign rsp_err    = rd_err_r;
    end
  endgenerate

  // Busy covers the burst itself and every beat still inside the pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
    end else begin
      busy <= handshake | (state_r == ST_BURST) | iss_valid_r | tail_valid;
    end
  end

endmodule

// File: doc/arb_burst_rom.md
Name: arb_burst_rom

Overview:
- Parametrised successor to the single-port synchronous ROM: one memory array, binary-file initialised, shared by NUM_CH requesters.
- Each requester issues a burst read (start address + length).
- Round-robin arbitration grants one burst at a time; beats stream out on a shared response bus tagged with channel id, last flag and error flag.
- Used for sprite/table lookups, where several display/game units read constant data from one ROM.

Parameters:
- DATA_WIDTH, 32, word width.
- ADDRESS_WIDTH, 12, address width per channel.
- DEPTH, 250, number of words; valid addresses are 0..DEPTH-1.
- NUM_CH, 2, requester count, 1..8.
- LEN_WIDTH, 8, burst length field width; field value = beats-1.
- OUT_REG, 0, 1 adds an output pipeline register (+1 cycle latency).
- MEMFILE, "", binary ($readmemb) init file; empty means all-zero contents.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_CH  per-channel burst request.
- req_ready  out  NUM_CH  per-channel accept; one-hot or zero.
- req_addr  in  NUM_CH*ADDRESS_WIDTH  start address; channel i at bits [i*AW +: AW].
- req_len  in  NUM_CH*LEN_WIDTH  beats-1; channel i at bits [i*LW +: LW].
- rsp_valid  out  1  response beat valid.
- rsp_ch  out  clog2(NUM_CH) (min 1)  channel owning the beat.
- rsp_data  out  DATA_WIDTH  read data.
- rsp_last  out  1  final beat of the burst.
- rsp_err  out  1  beat address was >= DEPTH.
- busy  out  1  burst in progress or beats in flight.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE; rr pointer=0; req_ready, rsp_valid, rsp_ch, rsp_data, rsp_last, rsp_err, busy all 0. Memory contents are not affected by reset.
- FSM has two states, IDLE and BURST.
- IDLE:
  - If any req_valid, grant the first requesting channel searching from rr pointer upward with wrap.
  - req_ready[g]=1 combinationally in that cycle. Handshake = req_valid[g]&req_ready[g] at the edge.
  - On handshake: latch cur_addr=req_addr[g], remaining=req_len[g], ch=g; rr pointer=(g+1) mod NUM_CH; go to BURST.
- BURST:
  - req_ready all 0.
  - Every cycle issue one read of cur_addr, tagged {ch, last=(remaining==0), err=(cur_addr>=DEPTH)}.
  - cur_addr increments; DEPTH-1 wraps to 0.
  - remaining decrements. Issuing the beat with remaining==0 returns to IDLE.
  - A burst of req_len=L yields exactly L+1 beats, no gaps.
- Out-of-range beat (address >= DEPTH): rsp_data=0, rsp_err=1. The array is never indexed out of bounds.
- An out-of-range start address increments normally without wrapping until it reaches 2^ADDRESS_WIDTH-1, then wraps to 0.
- Latency:
  - Handshake at edge k; first read issued in cycle k+1.
  - rsp_valid at edge k+2 (OUT_REG=0) or k+3 (OUT_REG=1).
  - Beats are contiguous.
- Throughput: minimum one IDLE cycle between bursts. Peak one beat/cycle.
- Response bus:
  - No backpressure; the consumer must sample while rsp_valid=1.
  - rsp_data, rsp_ch, rsp_last and rsp_err hold their last values when rsp_valid=0.
- busy=1 from the handshake edge until the edge after the last beat leaves the output.
- Request inputs may change freely while not ready; they are ignored outside the handshake cycle.
- Reset mid-burst: burst abandoned, in-flight beats dropped (no rsp_valid after reset), rr=0.
- NUM_CH=1: rsp_ch is constant 0.
- LEN_WIDTH may exceed ADDRESS_WIDTH; long bursts wrap repeatedly.

Decomposition:
- Shared package holds: clog2 function, CH_W width derivation, state encoding constants (IDLE/BURST).
- One natural sub-module, rr_arbiter: NUM_CH request vector plus pointer in, one-hot grant and index out; purely combinational. The pointer register stays in the top.
- The memory array and read register stay in the top.

Test Plan:
- Preload word[n]=n+100; ch0 req addr=5 len=3 (OUT_REG=0) -> rsp_valid at handshake+2 for 4 cycles. Data 105,106,107,108, rsp_ch=0, rsp_last only on 108, rsp_err=0, busy drops the cycle after.
- ch0 and ch1 both request continuously with len=0, addr0=1, addr1=2 -> grants alternate 0,1,0,1 starting with ch0. rsp_ch alternates; data 101,102,101,102.
- DEPTH=250, addr=248 len=3 -> data 348,349,100,101 (wrap to 0); rsp_err=0 throughout.
- addr=300 len=1 -> two beats, data 0, rsp_err=1, rsp_last on the second.
- OUT_REG=1, addr=0 len=0 -> single beat at handshake+3, data 100, rsp_last=1.
- Start len=15 burst, pull reset_n low after 4 beats for 1 cycle -> outputs 0 immediately. No further rsp_valid. A subsequent ch1-only request is granted on the first IDLE cycle.
